// File: rtl/uart_frame_loader.sv
// Framed UART byte-stream loader: A5, addr hi/lo, len, payload[, chk] -> memory writes.
// Optional trailing XOR checksum byte enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_loader #(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_data_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int TW = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AHI,
      S_ALO,
      S_LEN,
`ifdef UART_FRAME_CHECKSUM_EN
      S_PAY,
      S_CHK
`else
      S_PAY
`endif
   } state_t;

   state_t                state;
   logic [7:0]            addr_hi;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [7:0]            cnt;
   logic [TW-1:0]         tmr;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0]            chk;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr_hi    <= '0;
         ptr        <= '0;
         cnt        <= '0;
         tmr        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= 2'b00;
         busy       <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         chk        <= '0;
`endif
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (state == S_IDLE || rx_data_ready)
            tmr <= '0;
         else
            tmr <= tmr + TW'(1);

         // An arriving byte always takes priority over an expiring timer
         if (rx_data_ready) begin
            case (state)
               S_IDLE: begin
                  if (rx_data == 8'hA5) begin
                     state <= S_AHI;
                     busy  <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                     chk   <= '0;
`endif
                  end
               end
               S_AHI: begin
                  addr_hi <= rx_data;
                  state   <= S_ALO;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk     <= chk ^ rx_data;
`endif
               end
               S_ALO: begin
                  ptr   <= ADDR_WIDTH'({addr_hi, rx_data});
                  state <= S_LEN;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk   <= chk ^ rx_data;
`endif
               end
               S_LEN: begin
                  if (rx_data == 8'd0) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b11;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     cnt   <= rx_data;
                     state <= S_PAY;
                  end
`ifdef UART_FRAME_CHECKSUM_EN
                  chk <= chk ^ rx_data;
`endif
               end
               S_PAY: begin
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= rx_data;
                  ptr     <= ptr + ADDR_WIDTH'(1);
                  cnt     <= cnt - 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk     <= chk ^ rx_data;
                  if (cnt == 8'd1)
                     state <= S_CHK;
`else
                  if (cnt == 8'd1) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end
`endif
               end
`ifdef UART_FRAME_CHECKSUM_EN
               S_CHK: begin
                  if (chk == rx_data) begin
                     frame_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b01;
                  end
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
`endif
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end else if (state != S_IDLE && tmr == TMAX) begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            busy      <= 1'b0;
            state     <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader; covers both checksum build options.
// Expected writes, pulse counts and pulse cycles are hand-derived per frame.
module tb_uart_frame_loader;

   localparam int AW = 10;
   localparam int TO = 100;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_data_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic          frame_err;
   logic [1:0]    err_code;
   logic          busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_done, n_err, done_cyc, err_cyc, last_strobe, t0;
   logic [1:0]    last_code;
   logic [AW-1:0] wa[$];
   logic [7:0]    wd[$];

   uart_frame_loader #(
      .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_data_ready(rx_data_ready),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .frame_done(frame_done),
      .frame_err(frame_err),
      .err_code(err_code),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
      end
      if (frame_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (frame_err) begin
         n_err++;
         err_cyc = cyc;
         last_code = err_code;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear();
      wa.delete();
      wd.delete();
      n_done = 0;
      n_err = 0;
      done_cyc = -1;
      err_cyc = -1;
      last_code = 2'b00;
   endtask

   task automatic put(input logic [7:0] b);
      rx_data = b;
      rx_data_ready = 1'b1;
      @(posedge clk);
      #1;
      last_strobe = cyc;
   endtask

   task automatic gap(input int n);
      rx_data_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input int n,
                             input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic bad, input int g);
      logic [7:0] p [3];
      logic [7:0] x;
      p[0] = p0;
      p[1] = p1;
      p[2] = p2;
      x = hi ^ lo ^ 8'(n);
      put(8'hA5);
      check("busy_up", busy, 1);
      if (g > 0) gap(g);
      put(hi);
      if (g > 0) gap(g);
      put(lo);
      if (g > 0) gap(g);
      put(8'(n));
      if (g > 0) gap(g);
      for (int i = 0; i < n; i++) begin
         put(p[i]);
         x = x ^ p[i];
         if (g > 0) gap(g);
      end
      if (CS_EN && n > 0) put(bad ? 8'h00 : x);
      rx_data_ready = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_err"}, frame_err, 0);
      check({tag, "_code"}, err_code, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      rx_data = 8'h00;
      rx_data_ready = 1'b0;
      clear();
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      gap(2);

      // Frame 1: chk = 01^20^03^11^22^33 = 22
      clear();
      send_frame(8'h01, 8'h20, 3, 8'h11, 8'h22, 8'h33, 1'b0, 1);
      t0 = last_strobe;
      gap(3);
      check("f1_nwr", wa.size(), 3);
      check("f1_a0", wa[0], 10'h120);
      check("f1_d0", wd[0], 8'h11);
      check("f1_a1", wa[1], 10'h121);
      check("f1_d1", wd[1], 8'h22);
      check("f1_a2", wa[2], 10'h122);
      check("f1_d2", wd[2], 8'h33);
      check("f1_done", n_done, 1);
      check("f1_done_cyc", done_cyc, t0);
      check("f1_err", n_err, 0);
      check("f1_busy", busy, 0);

`ifdef UART_FRAME_CHECKSUM_EN
      clear();
      send_frame(8'h01, 8'h20, 3, 8'h11, 8'h22, 8'h33, 1'b1, 0);
      t0 = last_strobe;
      gap(3);
      check("bad_nwr", wa.size(), 3);
      check("bad_a2", wa[2], 10'h122);
      check("bad_d2", wd[2], 8'h33);
      check("bad_err", n_err, 1);
      check("bad_code", last_code, 2'b01);
      check("bad_err_cyc", err_cyc, t0);
      check("bad_done", n_done, 0);
`endif

      clear();
      send_frame(8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0, 0);
      t0 = last_strobe;
      gap(3);
      check("zl_nwr", wa.size(), 0);
      check("zl_err", n_err, 1);
      check("zl_code", last_code, 2'b11);
      check("zl_err_cyc", err_cyc, t0);
      check("zl_done", n_done, 0);
      check("zl_busy", busy, 0);
      check("zl_code_held", err_code, 2'b11);

      // Stalled frame: LEN=2 but only one payload byte arrives
      clear();
      put(8'hA5);
      put(8'h03);
      put(8'hFF);
      put(8'h02);
      put(8'hAA);
      t0 = last_strobe;
      gap(TO + 20);
      check("to_nwr", wa.size(), 1);
      check("to_a0", wa[0], 10'h3FF);
      check("to_d0", wd[0], 8'hAA);
      check("to_err", n_err, 1);
      check("to_code", last_code, 2'b10);
      check("to_delay", err_cyc - t0, TO);
      check("to_done", n_done, 0);
      check("to_busy", busy, 0);

      clear();
      send_frame(8'h03, 8'hFF, 2, 8'hBB, 8'hCC, 8'h00, 1'b0, 0);
      gap(3);
      check("wr_nwr", wa.size(), 2);
      check("wr_a0", wa[0], 10'h3FF);
      check("wr_a1", wa[1], 10'h000);
      check("wr_d1", wd[1], 8'hCC);
      check("wr_done", n_done, 1);

      // Garbage then two frames, all back-to-back strobes
      clear();
      put(8'h00);
      put(8'hFF);
      put(8'h5A);
      check("gb_busy", busy, 0);
      send_frame(8'h00, 8'h10, 2, 8'hDE, 8'hAD, 8'h00, 1'b0, 0);
      send_frame(8'h02, 8'h00, 1, 8'h77, 8'h00, 8'h00, 1'b0, 0);
      t0 = last_strobe;
      gap(3);
      check("bb_nwr", wa.size(), 3);
      check("bb_a0", wa[0], 10'h010);
      check("bb_d0", wd[0], 8'hDE);
      check("bb_a1", wa[1], 10'h011);
      check("bb_d1", wd[1], 8'hAD);
      check("bb_a2", wa[2], 10'h200);
      check("bb_d2", wd[2], 8'h77);
      check("bb_done", n_done, 2);
      check("bb_done_cyc", done_cyc, t0);
      check("bb_err", n_err, 0);

      // Reset in the middle of a payload
      put(8'hA5);
      put(8'h01);
      put(8'h00);
      put(8'h04);
      put(8'h01);
      put(8'h02);
      check("mid_wr_en", wr_en, 1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      rx_data_ready = 1'b0;
      gap(2);
      rst_n = 1'b1;
      gap(2);
      clear();
      send_frame(8'h00, 8'h40, 1, 8'h99, 8'h00, 8'h00, 1'b0, 0);
      gap(3);
      check("rr_nwr", wa.size(), 1);
      check("rr_a0", wa[0], 10'h040);
      check("rr_d0", wd[0], 8'h99);
      check("rr_done", n_done, 1);
      check("rr_err", n_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
